// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular receive buffer between the UART receiver and the host.
// It stores each rx_dout word qualified by rx_done_tick. The consumer reads
// words through a rd_en / rd_valid handshake. Status flags are derived only
// from registered pointers, so they do not depend combinationally on strobes.
// Optional feature macro: UART_RX_FIFO_OVF_FLAG_EN adds a sticky overflow flag
// (overflow) and its clear input (ovf_clr).
// Note: rst_n is an asynchronous reset that is active-high.
module uart_rx_fifo #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_done_tick,
    input  logic [DBIT-1:0]   rx_dout,
    input  logic              rd_en,
    output logic [DBIT-1:0]   rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
`ifdef UART_RX_FIFO_OVF_FLAG_EN
    output logic              overflow,
    input  logic              ovf_clr,
`endif
    output logic [ADDR_W:0]   count
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DBIT-1:0] mem_q [DEPTH];
    logic [ADDR_W:0] wp_q, wp_d;
    logic [ADDR_W:0] rp_q, rp_d;
    logic [DBIT-1:0] rd_data_q, rd_data_d;
    logic            rd_valid_q, rd_valid_d;
    logic            rd_acc;
    logic            wr_acc;

    // Status flags. The extra pointer MSB separates the full case from the empty case.
    always_comb begin
        empty = (wp_q == rp_q);
        full  = (wp_q[ADDR_W-1:0] == rp_q[ADDR_W-1:0]) && (wp_q[ADDR_W] != rp_q[ADDR_W]);
        count = wp_q - rp_q;
    end

    // Accept decisions and next-state values for the pointers and read port.
    // A write into a full FIFO is accepted when a read frees a slot in the same
    // cycle. The slot written is then the one being read, and the read takes the
    // old word because the memory update is non-blocking.
    always_comb begin
        rd_acc     = rd_en && !empty;
        wr_acc     = rx_done_tick && (!full || rd_acc);
        wp_d       = wp_q + (ADDR_W+1)'(wr_acc);
        rp_d       = rp_q + (ADDR_W+1)'(rd_acc);
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_acc;
        if (rd_acc) begin
            rd_data_d = mem_q[rp_q[ADDR_W-1:0]];
        end
    end

    // Pointer and read-port registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wp_q       <= '0;
            rp_q       <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage array. It is not reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wp_q[ADDR_W-1:0]] <= rx_dout;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

`ifdef UART_RX_FIFO_OVF_FLAG_EN
    logic overflow_q, overflow_d;
    logic drop;

    // Sticky drop flag. A drop in the same cycle as a clear wins, so no drop goes unreported.
    always_comb begin
        drop       = rx_done_tick && full && !rd_acc;
        overflow_d = drop || (overflow_q && !ovf_clr);
    end

    // Overflow flag register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
// Inputs change on the falling edge. Outputs are sampled 1 time unit after the rising edge.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_dout = 8'h00;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       ovf_clr = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DBIT(8), .ADDR_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_done_tick (rx_done_tick),
        .rx_dout      (rx_dout),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .full         (full),
`ifdef UART_RX_FIFO_OVF_FLAG_EN
        .overflow     (overflow),
        .ovf_clr      (ovf_clr),
`endif
        .count        (count)
    );

`ifndef UART_RX_FIFO_OVF_FLAG_EN
    assign overflow = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit tick, input logic [7:0] d, input bit rd, input bit clr = 1'b0);
        @(negedge clk);
        rx_done_tick = tick;
        rx_dout      = d;
        rd_en        = rd;
        ovf_clr      = clr;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] v;
    logic [7:0] prev;

    initial begin
        // Reset, then idle
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        @(negedge clk);
        rst_n = 1'b0;
        step(0, 8'h00, 0);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_count", count, 5'd0);
        check("rst_overflow", overflow, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h00, 1);
            check("empty_rd_valid", rd_valid, 1'b0);
            check("empty_rd_data", rd_data, 8'h00);
        end

        // Three writes, then three reads
        step(1, 8'hA5, 0);
        check("w1_count", count, 5'd1);
        check("w1_empty", empty, 1'b0);
        step(1, 8'h3C, 0);
        step(1, 8'h7E, 0);
        check("w3_count", count, 5'd3);
        step(0, 8'h00, 1);
        check("r1_valid", rd_valid, 1'b1);
        check("r1_data", rd_data, 8'hA5);
        step(0, 8'h00, 1);
        check("r2_data", rd_data, 8'h3C);
        step(0, 8'h00, 1);
        check("r3_data", rd_data, 8'h7E);
        check("r3_valid", rd_valid, 1'b1);
        step(0, 8'h00, 0);
        check("r_idle_valid", rd_valid, 1'b0);
        check("r_idle_data_hold", rd_data, 8'h7E);
        check("r_done_empty", empty, 1'b1);

        // Fill to 16, then one dropped write
        for (int i = 0; i < 16; i++) begin
            step(1, 8'(i), 0);
        end
        check("fill_full", full, 1'b1);
        check("fill_count", count, 5'd16);
        step(1, 8'hFF, 0);
        check("drop_count", count, 5'd16);
        check("drop_full", full, 1'b1);
`ifdef UART_RX_FIFO_OVF_FLAG_EN
        check("drop_ovf_set", overflow, 1'b1);
        step(0, 8'h00, 0, 1);
        check("ovf_clr", overflow, 1'b0);
        step(1, 8'hFE, 0, 1);
        check("ovf_set_wins", overflow, 1'b1);
        step(0, 8'h00, 0, 1);
        check("ovf_clr2", overflow, 1'b0);
`endif
        for (int i = 0; i < 16; i++) begin
            step(0, 8'h00, 1);
            check("drain_data", rd_data, 32'(i));
            check("drain_valid", rd_valid, 1'b1);
        end
        check("drain_empty", empty, 1'b1);
        step(0, 8'h00, 1);
        check("drain_no_extra", rd_valid, 1'b0);

        // Write and read together while full
        for (int i = 0; i < 16; i++) begin
            step(1, 8'(i), 0);
        end
        step(1, 8'h55, 1);
        check("fullrw_data", rd_data, 8'h00);
        check("fullrw_valid", rd_valid, 1'b1);
        check("fullrw_count", count, 5'd16);
        check("fullrw_ovf", overflow, 1'b0);
        for (int i = 1; i < 16; i++) begin
            step(0, 8'h00, 1);
            check("fullrw_drain", rd_data, 32'(i));
        end
        step(0, 8'h00, 1);
        check("fullrw_last", rd_data, 8'h55);
        check("fullrw_empty", empty, 1'b1);

        // Write and read together while empty
        step(1, 8'h11, 1);
        check("emptyrw_valid", rd_valid, 1'b0);
        check("emptyrw_count", count, 5'd1);
        check("emptyrw_hold", rd_data, 8'h55);
        step(0, 8'h00, 1);
        check("emptyrw_read", rd_data, 8'h11);
        check("emptyrw_rvalid", rd_valid, 1'b1);

        // Reset asserted mid-stream
        for (int i = 0; i < 4; i++) begin
            step(1, 8'h20 + 8'(i), 0);
        end
        @(negedge clk);
        rx_done_tick = 1'b1;
        rx_dout      = 8'h24;
        rd_en        = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        check("midrst_count_async", count, 5'd0);
        @(posedge clk);
        #1;
        check("midrst_empty", empty, 1'b1);
        check("midrst_count", count, 5'd0);
        check("midrst_rd_data", rd_data, 8'h00);
        @(negedge clk);
        rst_n        = 1'b0;
        rx_done_tick = 1'b0;
        step(1, 8'h99, 0);
        check("postrst_count", count, 5'd1);
        step(0, 8'h00, 1);
        check("postrst_read", rd_data, 8'h99);

        // Sustained write+read across pointer wrap, one word in flight
        prev = 8'h03;
        step(1, prev, 0);
        for (int i = 1; i <= 40; i++) begin
            v = 8'(i * 7 + 3);
            step(1, v, 1);
            check("wrap_data", rd_data, prev);
            check("wrap_valid", rd_valid, 1'b1);
            check("wrap_count", count, 5'd1);
            prev = v;
        end
        step(0, 8'h00, 1);
        check("wrap_last", rd_data, prev);
        check("wrap_empty", empty, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
